// File: rtl/matmul_pkg.sv
// Shared types and index helpers for the NxN matrix multiply engine.
package matmul_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      COMPUTE = 1'b1
   } state_t;

   function automatic int addr_width(input int n);
      return (n * n > 1) ? $clog2(n * n) : 1;
   endfunction

   function automatic int idx(input int i, input int j, input int n);
      return i * n + j;
   endfunction

endpackage

// File: rtl/matmul_mac.sv
// Combinational multiply-accumulate step: sum = base + a*b, wrapped to CWIDTH.
module matmul_mac #(
   parameter int DWIDTH = 16,
   parameter int CWIDTH = 2 * DWIDTH,
   parameter bit SIGNED = 1'b0
) (
   input  logic [DWIDTH-1:0] a,
   input  logic [DWIDTH-1:0] b,
   input  logic [CWIDTH-1:0] base,
   output logic [CWIDTH-1:0] sum
);

   localparam int PW = 2 * DWIDTH;
   localparam int EW = (CWIDTH > PW) ? CWIDTH : PW;

   logic [EW-1:0] prod_ext;

   generate
      if (SIGNED) begin : g_signed
         logic signed [DWIDTH-1:0] sa;
         logic signed [DWIDTH-1:0] sb;
         logic signed [PW-1:0]     p;
         assign sa = a;
         assign sb = b;
         assign p = PW'(sa) * PW'(sb);
         assign prod_ext = EW'(p);
      end else begin : g_unsigned
         logic [PW-1:0] p;
         assign p = PW'(a) * PW'(b);
         assign prod_ext = EW'(p);
      end
   endgenerate

   assign sum = base + prod_ext[CWIDTH-1:0];

endmodule

// File: rtl/matmul_nxn_engine.sv
// NxN matrix multiplier: register-file operands, one shared MAC, C = A*B or C += A*B.
//
// state   | meaning
// IDLE    | operands/result writable, waiting for start
// COMPUTE | stepping i/j/k through N^3 MAC cycles
module matmul_nxn_engine
   import matmul_pkg::*;
#(
   parameter int N      = 8,
   parameter int DWIDTH = 16,
   parameter int CWIDTH = 2 * DWIDTH,
   parameter bit SIGNED = 1'b0,
   parameter int AWIDTH = addr_width(N)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we1,
   input  logic              we2,
   input  logic [AWIDTH-1:0] addr_pi,
   input  logic [DWIDTH-1:0] data_pi,
   input  logic              start,
   input  logic              accum,
   input  logic [AWIDTH-1:0] out_sel,
   output logic [CWIDTH-1:0] data_out,
   output logic              busy,
   output logic              done_mat_mul
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int NN = N * N;

   state_t            state_q, state_d;
   logic [CW-1:0]     i_q, j_q, k_q;
   logic              mode_acc;
   logic [CWIDTH-1:0] acc_q;
   logic [CWIDTH-1:0] base;
   logic [CWIDTH-1:0] sum;
   logic [AWIDTH-1:0] a_idx, b_idx, c_idx;
   logic              i_last, j_last, k_last, last_step;
   logic              start_ok, wr_ok;

   logic [DWIDTH-1:0] a_mem [NN];
   logic [DWIDTH-1:0] b_mem [NN];
   logic [CWIDTH-1:0] c_mem [NN];

   assign i_last    = (i_q == CW'(N - 1));
   assign j_last    = (j_q == CW'(N - 1));
   assign k_last    = (k_q == CW'(N - 1));
   assign last_step = i_last && j_last && k_last;
   assign wr_ok     = (state_q == IDLE) && (int'(addr_pi) < NN);

   assign a_idx = AWIDTH'(idx(int'(i_q), int'(k_q), N));
   assign b_idx = AWIDTH'(idx(int'(k_q), int'(j_q), N));
   assign c_idx = AWIDTH'(idx(int'(i_q), int'(j_q), N));

   always_comb begin
      state_d  = state_q;
      busy     = 1'b0;
      start_ok = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               start_ok = 1'b1;
               state_d  = COMPUTE;
            end
         end
         COMPUTE: begin
            busy = 1'b1;
            if (last_step) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // First inner-product term starts from C (accumulate) or zero; later terms chain through acc.
   always_comb begin
      base = '0;
      if (k_q == '0) begin
         if (mode_acc) base = c_mem[c_idx];
      end else begin
         base = acc_q;
      end
   end

   matmul_mac #(
      .DWIDTH (DWIDTH),
      .CWIDTH (CWIDTH),
      .SIGNED (SIGNED)
   ) u_mac (
      .a    (a_mem[a_idx]),
      .b    (b_mem[b_idx]),
      .base (base),
      .sum  (sum)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         i_q          <= '0;
         j_q          <= '0;
         k_q          <= '0;
         mode_acc     <= 1'b0;
         acc_q        <= '0;
         done_mat_mul <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_ok) begin
            i_q          <= '0;
            j_q          <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            mode_acc     <= accum;
            done_mat_mul <= 1'b0;
         end else if (busy) begin
            if (last_step) done_mat_mul <= 1'b1;
            if (k_last) begin
               k_q <= '0;
               if (j_last) begin
                  j_q <= '0;
                  i_q <= i_last ? '0 : i_q + CW'(1);
               end else begin
                  j_q <= j_q + CW'(1);
               end
            end else begin
               acc_q <= sum;
               k_q   <= k_q + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int e = 0; e < NN; e++) begin
            a_mem[e] <= '0;
            b_mem[e] <= '0;
         end
      end else if (wr_ok) begin
         if (we1) a_mem[addr_pi] <= data_pi;
         if (we2) b_mem[addr_pi] <= data_pi;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int e = 0; e < NN; e++) c_mem[e] <= '0;
      end else if (busy && k_last) begin
         c_mem[c_idx] <= sum;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out <= '0;
      end else if (int'(out_sel) < NN) begin
         data_out <= c_mem[out_sel];
      end else begin
         data_out <= '0;
      end
   end

endmodule

// File: tb/tb_matmul_nxn_engine.sv
// Directed bench for matmul_nxn_engine: unsigned (default) and signed instances share stimulus.
module tb_matmul_nxn_engine;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        we1 = 1'b0, we2 = 1'b0, start = 1'b0, accum = 1'b0;
   logic [5:0]  addr_pi = '0, out_sel = '0;
   logic [15:0] data_pi = '0;
   logic [31:0] data_out, s_data_out;
   logic        busy, done_mat_mul, s_busy, s_done;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] ma [64];
   logic [15:0] mb [64];
   logic [31:0] mc [64];

   always #5 clk = ~clk;

   matmul_nxn_engine u_dut (
      .clk (clk), .reset (reset), .we1 (we1), .we2 (we2),
      .addr_pi (addr_pi), .data_pi (data_pi), .start (start), .accum (accum),
      .out_sel (out_sel), .data_out (data_out), .busy (busy),
      .done_mat_mul (done_mat_mul)
   );

   matmul_nxn_engine #(.SIGNED(1'b1)) u_sdut (
      .clk (clk), .reset (reset), .we1 (we1), .we2 (we2),
      .addr_pi (addr_pi), .data_pi (data_pi), .start (start), .accum (accum),
      .out_sel (out_sel), .data_out (s_data_out), .busy (s_busy),
      .done_mat_mul (s_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Unsigned reference: plain triple loop, wraps at 32 bits.
   task automatic model_mm();
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            logic [31:0] s;
            s = '0;
            for (int k = 0; k < 8; k++) s = s + 32'(ma[i*8+k]) * 32'(mb[k*8+j]);
            mc[i*8+j] = s;
         end
   endtask

   task automatic load(input logic w1, input logic w2);
      for (int e = 0; e < 64; e++) begin
         @(negedge clk);
         addr_pi = 6'(e);
         data_pi = w1 ? ma[e] : mb[e];
         we1 = w1;
         we2 = w2;
      end
      @(negedge clk);
      we1 = 1'b0;
      we2 = 1'b0;
   endtask

   task automatic rd(input int e, output logic [31:0] u, output logic [31:0] s);
      @(negedge clk);
      out_sel = 6'(e);
      @(negedge clk);
      u = data_out;
      s = s_data_out;
   endtask

   // Starts a compute and counts busy cycles at negedges; optional injection / early exit.
   task automatic run(input logic acc, input int inject_at, input int abort_at, output int cnt);
      @(negedge clk);
      start = 1'b1;
      accum = acc;
      @(negedge clk);
      start = 1'b0;
      check("done_clear_on_start", {31'd0, done_mat_mul}, 32'd0);
      cnt = 0;
      while (busy && cnt < 2000) begin
         cnt++;
         if (cnt == abort_at) return;
         if (cnt == inject_at) begin
            start = 1'b1;
            we1 = 1'b1;
            addr_pi = '0;
            data_pi = 16'd7;
         end
         @(negedge clk);
         start = 1'b0;
         we1 = 1'b0;
      end
   endtask

   task automatic check_run(input int cnt, input string tag);
      check({tag, "_busy_len"}, cnt, 512);
      check({tag, "_done"}, {31'd0, done_mat_mul}, 32'd1);
   endtask

   initial begin
      int cnt;
      logic [31:0] u, s;

      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done_mat_mul}, 32'd0);
      check("rst_data_out", data_out, 32'd0);
      reset = 1'b0;
      rd(5, u, s);
      check("rst_c5", u, 32'd0);

      // Identity times ramp
      for (int e = 0; e < 64; e++) begin
         ma[e] = (e / 8 == e % 8) ? 16'd1 : 16'd0;
         mb[e] = 16'(e);
      end
      load(1'b1, 1'b0);
      load(1'b0, 1'b1);
      run(1'b0, 0, 0, cnt);
      check_run(cnt, "ident");
      for (int e = 0; e < 64; e++) begin
         rd(e, u, s);
         check($sformatf("ident_c[%0d]", e), u, 32'(e));
      end

      run(1'b1, 0, 0, cnt);
      check_run(cnt, "accum");
      for (int e = 0; e < 64; e++) begin
         rd(e, u, s);
         check($sformatf("accum_c[%0d]", e), u, 32'(2 * e));
      end

      run(1'b0, 0, 0, cnt);
      check_run(cnt, "reload");
      for (int e = 0; e < 64; e++) begin
         rd(e, u, s);
         check($sformatf("reload_c[%0d]", e), u, 32'(e));
      end

      // All 0xFFFF via simultaneous we1/we2: unsigned wraps, signed sees (-1)(-1)*8
      for (int e = 0; e < 64; e++) ma[e] = 16'hFFFF;
      load(1'b1, 1'b1);
      run(1'b0, 0, 0, cnt);
      check_run(cnt, "wrap");
      for (int e = 0; e < 64; e += 9) begin
         rd(e, u, s);
         check($sformatf("wrap_u_c[%0d]", e), u, 32'hFFF0_0008);
         check($sformatf("wrap_s_c[%0d]", e), s, 32'h0000_0008);
      end

      // A = -1, B = 2
      for (int e = 0; e < 64; e++) mb[e] = 16'd2;
      load(1'b0, 1'b1);
      run(1'b0, 0, 0, cnt);
      check_run(cnt, "signed");
      for (int e = 0; e < 64; e += 7) begin
         rd(e, u, s);
         check($sformatf("signed_s_c[%0d]", e), s, 32'hFFFF_FFF0);
         check($sformatf("signed_u_c[%0d]", e), u, 32'h000F_FFF0);
      end

      // Start and write to A[0] during compute must be ignored
      for (int e = 0; e < 64; e++) begin
         ma[e] = 16'(e + 1);
         mb[e] = 16'((3 * e) % 7);
      end
      model_mm();
      load(1'b1, 1'b0);
      load(1'b0, 1'b1);
      run(1'b0, 100, 0, cnt);
      check_run(cnt, "busyprot");
      for (int e = 0; e < 64; e++) begin
         rd(e, u, s);
         check($sformatf("busyprot_c[%0d]", e), u, mc[e]);
      end

      // Reset mid-compute
      out_sel = 6'd10;
      run(1'b0, 0, 200, cnt);
      check("abort_reached", cnt, 200);
      reset = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done_mat_mul}, 32'd0);
      check("abort_data_out", data_out, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int e = 0; e < 64; e++) begin
         rd(e, u, s);
         check($sformatf("abort_c[%0d]", e), u, 32'd0);
      end

      for (int e = 0; e < 64; e++) begin
         ma[e] = 16'(e % 5);
         mb[e] = 16'((e % 3) + 1);
      end
      model_mm();
      load(1'b1, 1'b0);
      load(1'b0, 1'b1);
      run(1'b0, 0, 0, cnt);
      check_run(cnt, "fresh");
      for (int e = 0; e < 64; e++) begin
         rd(e, u, s);
         check($sformatf("fresh_c[%0d]", e), u, mc[e]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/matmul_nxn_engine.md
Name: matmul_nxn_engine

Overview:
Parametrised successor to the fixed 8x8 matrix multiplier. Holds two NxN operand matrices (A, B) and one NxN result matrix (C) in internal register files. A, B and C are loaded and read through the same we1/we2/addr_pi/data_pi/out_sel style port. On a start pulse, a single multiply-accumulate datapath computes C = A*B, or C += A*B in accumulate mode. Signed or unsigned arithmetic is selected at elaboration time.

Parameters:
N, 8, matrix dimension (N >= 2)
DWIDTH, 16, operand element width
CWIDTH, 2*DWIDTH, result element width; accumulation wraps modulo 2^CWIDTH
SIGNED, 0, 1 = two's-complement operands and products, 0 = unsigned
AWIDTH, $clog2(N*N), element address width (derived; do not override)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
we1  in  1  write data_pi into A[addr_pi]
we2  in  1  write data_pi into B[addr_pi]
addr_pi  in  AWIDTH  row-major element address, i*N+j
data_pi  in  DWIDTH  write data
start  in  1  single-cycle request to begin multiplication
accum  in  1  sampled with start: 1 = C += A*B, 0 = C = A*B
out_sel  in  AWIDTH  row-major C element to read
data_out  out  CWIDTH  registered C[out_sel]
busy  out  1  high while computing
done_mat_mul  out  1  level; high from end of compute until next accepted start

Behaviour:
- Reset (asynchronous): A, B and C are cleared to 0. The FSM goes to IDLE. busy=0, done_mat_mul=0, data_out=0. Counters and accumulator are cleared. Assertion mid-compute aborts the compute immediately; no partial state is retained.
- Writes: accepted only when busy=0.
  - we1 and we2 may both be high in the same cycle; both writes are then performed at addr_pi.
  - addr_pi >= N*N: write is ignored.
  - Writes while busy=1 are dropped silently.
- Read: data_out <= C[out_sel] every cycle (1-cycle latency), including while busy; during busy it may show partially updated C. out_sel >= N*N gives data_out=0.
- FSM:
  - IDLE -> COMPUTE when start=1 and busy=0. That edge latches accum into mode_acc, zeroes i/j/k and clears done_mat_mul.
  - start while busy is ignored.
  - COMPUTE runs N^3 cycles, nested i (row), j (col), k (inner); k increments fastest.
  - COMPUTE -> IDLE on the edge after i=j=k=N-1. That edge sets done_mat_mul=1.
- Per COMPUTE cycle:
  - prod = A[i*N+k] * B[k*N+j], signed or unsigned per SIGNED, extended to CWIDTH.
  - base = (k==0) ? (mode_acc ? C[i*N+j] : 0) : acc.
  - sum = base + prod, truncated to CWIDTH.
  - If k<N-1: acc <= sum. If k==N-1: C[i*N+j] <= sum.
- Timing: busy=1 for exactly N^3 cycles after the start edge (512 for N=8). done_mat_mul rises on the edge where busy falls.
- Widths: truncation is mod 2^CWIDTH. There is no saturation and no overflow flag.
- Simultaneous start and we1/we2 in IDLE: the write is performed and the compute starts on the same edge; the compute uses the newly written value.

Decomposition:
- Package matmul_pkg holds:
  - the FSM state enum (IDLE, COMPUTE)
  - an address-width helper function
  - a row-major index function idx(i,j,N)
- One sub-module, matmul_mac: combinational multiply (SIGNED-controlled) plus add, base/prod in, CWIDTH sum out. It is instantiated once.

Test Plan:
- Identity: load A=I, B[e]=e for e=0..63, start with accum=0 -> busy for exactly 512 cycles, then done_mat_mul=1; reading C[e] returns e for all 64 elements.
- Accumulate: after the identity run, start with accum=1 -> C[e]=2e. Start again with accum=0 -> C[e]=e.
- Unsigned wrap: A and B all 0xFFFF, SIGNED=0 -> every C element = 0xFFF00008.
- Signed: SIGNED=1, A all 0xFFFF (-1), B all 2 -> every C element = 0xFFFFFFF0 (-16).
- Busy protection: pulse start and we1 (addr 0, data 7) at cycle 100 of a compute -> busy length is unchanged (512 cycles) and A[0] is unchanged, with results matching the reference model.
- Reset mid-compute: assert reset at cycle 200 of a compute -> busy=0, done_mat_mul=0 and data_out=0 immediately; after release, all C elements read 0; a fresh load and start computes correctly.
